// File: rtl/segasys1_vid_pkg.sv
// Shared definitions for the SEGASYS1 raster timing / video output stage.
// Optional feature macro: VOUT_SCANLINE_EN (adds PV[0] to the flag bundle for the scanline effect).
package segasys1_vid_pkg;

  // Default raster timing
  localparam int unsigned DEF_H_TOTAL  = 384;
  localparam int unsigned DEF_H_VIS    = 256;
  localparam int unsigned DEF_HS_START = 288;
  localparam int unsigned DEF_HS_LEN   = 32;
  localparam int unsigned DEF_V_TOTAL  = 262;
  localparam int unsigned DEF_V_VIS    = 224;
  localparam int unsigned DEF_VS_START = 232;
  localparam int unsigned DEF_VS_LEN   = 3;
  localparam int unsigned DEF_PIX_LAT  = 2;

  // Raster flags travelling alongside the pixel pipeline
`ifdef VOUT_SCANLINE_EN
  typedef struct packed {
    logic pv0;
    logic fr;
    logic vs;
    logic hs;
    logic vb;
    logic hb;
  } vid_flags_t;
`else
  typedef struct packed {
    logic fr;
    logic vs;
    logic hs;
    logic vb;
    logic hb;
  } vid_flags_t;
`endif

  localparam int unsigned FLAGS_W = $bits(vid_flags_t);

  // BBGGGRRR -> {R8,G8,B8} by bit replication
  function automatic logic [23:0] rgb332_expand(input logic [7:0] rgb);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = rgb[2:0];
    g = rgb[5:3];
    b = rgb[7:6];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/sys1_vid_delay.sv
// Fixed-depth shift register with synchronous reset to a caller-supplied value.
module sys1_vid_delay
  import segasys1_vid_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  // Shift one stage per clock; reset loads every stage with rst_val
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= rst_val;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/segasys1_vtiming_out.sv
// Raster counters, blank/sync generation and RGB332 output stage for SEGASYS1 video.
// Flags are delayed PIX_LAT cycles to line up with the palette byte returned by the video block,
// then registered together with the expanded colour.
// VBL is the vertical blank output (VB is the blue channel).
// Optional feature macro: VOUT_SCANLINE_EN (halve colour on odd lines while SLEN=1).
module segasys1_vtiming_out
  import segasys1_vid_pkg::*;
#(
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned HS_START = DEF_HS_START,
  parameter int unsigned HS_LEN   = DEF_HS_LEN,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned VS_START = DEF_VS_START,
  parameter int unsigned VS_LEN   = DEF_VS_LEN,
  parameter int unsigned PIX_LAT  = DEF_PIX_LAT
) (
  input  logic       VCLK,
  input  logic       RESET,
  output logic [8:0] PH,
  output logic [8:0] PV,
  input  logic [7:0] RGB8,
  input  logic       SLEN,
  output logic [7:0] VR,
  output logic [7:0] VG,
  output logic [7:0] VB,
  output logic       HB,
  output logic       VBL,
  output logic       HS,
  output logic       VS,
  output logic       FRAME
);

  if (PIX_LAT < 1 || PIX_LAT > 7) begin : g_bad_pix_lat
    $error("PIX_LAT must be in the range 1..7");
  end

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_X = 10'(H_VIS);
  localparam logic [9:0] V_VIS_X = 10'(V_VIS);
  localparam logic [9:0] HS_LO   = 10'(HS_START);
  localparam logic [9:0] HS_HI   = 10'(HS_START + HS_LEN);
  localparam logic [9:0] VS_LO   = 10'(VS_START);
  localparam logic [9:0] VS_HI   = 10'(VS_START + VS_LEN);

  logic [8:0] ph_q, ph_d;
  logic [8:0] pv_q, pv_d;

  // Next raster position: PV advances only when PH wraps
  always_comb begin
    ph_d = ph_q + 9'd1;
    pv_d = pv_q;
    if (ph_q == H_LAST) begin
      ph_d = '0;
      pv_d = (pv_q == V_LAST) ? '0 : pv_q + 9'd1;
    end
  end

  // Raster counter registers
  always_ff @(posedge VCLK) begin
    if (RESET) begin
      ph_q <= '0;
      pv_q <= '0;
    end else begin
      ph_q <= ph_d;
      pv_q <= pv_d;
    end
  end

  assign PH = ph_q;
  assign PV = pv_q;

  vid_flags_t flags_raw;
  vid_flags_t flags_rst;
  vid_flags_t flags_tap;
  logic [9:0] ph_x;
  logic [9:0] pv_x;

  // Decode raw flags from the current position; reset value is blanked with no sync
  always_comb begin
    ph_x          = {1'b0, ph_q};
    pv_x          = {1'b0, pv_q};
    flags_raw     = '0;
    flags_raw.hb  = (ph_x >= H_VIS_X);
    flags_raw.vb  = (pv_x >= V_VIS_X);
    flags_raw.hs  = (ph_x >= HS_LO) && (ph_x < HS_HI);
    flags_raw.vs  = (pv_x >= VS_LO) && (pv_x < VS_HI);
    flags_raw.fr  = (ph_q == '0) && (pv_q == '0);
`ifdef VOUT_SCANLINE_EN
    flags_raw.pv0 = pv_q[0];
`endif
    flags_rst     = '0;
    flags_rst.hb  = 1'b1;
    flags_rst.vb  = 1'b1;
  end

  sys1_vid_delay #(
    .W     (FLAGS_W),
    .DEPTH (PIX_LAT)
  ) u_flag_delay (
    .clk     (VCLK),
    .rst     (RESET),
    .rst_val (flags_rst),
    .d       (flags_raw),
    .q       (flags_tap)
  );

  logic [23:0] rgb_exp;
  logic [7:0]  r_d, g_d, b_d;

`ifndef VOUT_SCANLINE_EN
  logic unused_slen;
  assign unused_slen = SLEN;
`endif

  // Expand palette byte, apply optional scanline dimming, then force black while blanked
  always_comb begin
    rgb_exp = rgb332_expand(RGB8);
    r_d     = rgb_exp[23:16];
    g_d     = rgb_exp[15:8];
    b_d     = rgb_exp[7:0];
`ifdef VOUT_SCANLINE_EN
    if (SLEN && flags_tap.pv0) begin
      r_d = {1'b0, r_d[7:1]};
      g_d = {1'b0, g_d[7:1]};
      b_d = {1'b0, b_d[7:1]};
    end
`endif
    if (flags_tap.hb || flags_tap.vb) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  logic [7:0] vr_q, vg_q, vb_q;
  logic       hb_q, vbl_q, hs_q, vs_q, frame_q;

  // Output register stage
  always_ff @(posedge VCLK) begin
    if (RESET) begin
      vr_q    <= '0;
      vg_q    <= '0;
      vb_q    <= '0;
      hb_q    <= 1'b1;
      vbl_q   <= 1'b1;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      vr_q    <= r_d;
      vg_q    <= g_d;
      vb_q    <= b_d;
      hb_q    <= flags_tap.hb;
      vbl_q   <= flags_tap.vb;
      hs_q    <= flags_tap.hs;
      vs_q    <= flags_tap.vs;
      frame_q <= flags_tap.fr;
    end
  end

  assign VR    = vr_q;
  assign VG    = vg_q;
  assign VB    = vb_q;
  assign HB    = hb_q;
  assign VBL   = vbl_q;
  assign HS    = hs_q;
  assign VS    = vs_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_segasys1_vtiming_out.sv
// Scoreboard bench: a default-timing instance plus a shrunken-raster instance so that
// frame wraps, vertical blank and VSYNC are reached within a short run.
`timescale 1ns/1ps
module tb_segasys1_vtiming_out;

  typedef struct packed {
    logic [8:0] ph;
    logic [8:0] pv;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       fr;
  } obs_t;

  // Small-raster instance timing
  localparam int S_HT = 24, S_HV = 16, S_HSS = 18, S_HSL = 3;
  localparam int S_VT = 10, S_VV = 7, S_VSS = 8, S_VSL = 2, S_LAT = 3;

  int ht  [2] = '{384, S_HT};
  int hv  [2] = '{256, S_HV};
  int hss [2] = '{288, S_HSS};
  int hsl [2] = '{32, S_HSL};
  int vt  [2] = '{262, S_VT};
  int vv  [2] = '{224, S_VV};
  int vss [2] = '{232, S_VSS};
  int vsl [2] = '{3, S_VSL};
  int lat [2] = '{2, S_LAT};

  logic       VCLK = 1'b0;
  logic       RESET;
  logic [7:0] RGB8;
  logic       SLEN;

  logic [8:0] ph0, pv0, ph1, pv1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       hb0, vb0, hs0, vs0, fr0, hb1, vb1, hs1, vs1, fr1;

  always #5 VCLK = ~VCLK;

  segasys1_vtiming_out u_dut (
    .VCLK (VCLK), .RESET (RESET), .PH (ph0), .PV (pv0), .RGB8 (RGB8), .SLEN (SLEN),
    .VR (r0), .VG (g0), .VB (b0), .HB (hb0), .VBL (vb0), .HS (hs0), .VS (vs0), .FRAME (fr0)
  );

  segasys1_vtiming_out #(
    .H_TOTAL (S_HT), .H_VIS (S_HV), .HS_START (S_HSS), .HS_LEN (S_HSL),
    .V_TOTAL (S_VT), .V_VIS (S_VV), .VS_START (S_VSS), .VS_LEN (S_VSL), .PIX_LAT (S_LAT)
  ) u_dut_small (
    .VCLK (VCLK), .RESET (RESET), .PH (ph1), .PV (pv1), .RGB8 (RGB8), .SLEN (SLEN),
    .VR (r1), .VG (g1), .VB (b1), .HB (hb1), .VBL (vb1), .HS (hs1), .VS (vs1), .FRAME (fr1)
  );

  obs_t exp_q0 [$];
  obs_t exp_q1 [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n     = 0;   // clock edges since the last reset edge

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.hb = 1'b1;
    o.vb = 1'b1;
    return o;
  endfunction

  // Reference: output after the coming edge, given n edges since reset and this cycle's inputs
  function automatic obs_t model(int k, int cnt, logic [7:0] rgb, logic sl);
    obs_t o;
    int   p, m, h, v, frame_len;
    o         = '0;
    frame_len = ht[k] * vt[k];
    p         = (cnt + 1) % frame_len;
    o.ph      = 9'(p % ht[k]);
    o.pv      = 9'(p / ht[k]);
    m         = cnt - lat[k];
    if (m < 0) begin
      o.hb = 1'b1;
      o.vb = 1'b1;
      return o;
    end
    p    = m % frame_len;
    h    = p % ht[k];
    v    = p / ht[k];
    o.hb = (h >= hv[k]);
    o.vb = (v >= vv[k]);
    o.hs = (h >= hss[k]) && (h < hss[k] + hsl[k]);
    o.vs = (v >= vss[k]) && (v < vss[k] + vsl[k]);
    o.fr = (p == 0);
    if (!o.hb && !o.vb) begin
      o.r = 8'((int'(rgb[2:0]) * 255 + 3) / 7);
      o.g = 8'((int'(rgb[5:3]) * 255 + 3) / 7);
      o.b = 8'(int'(rgb[7:6]) * 85);
`ifdef VOUT_SCANLINE_EN
      if (sl && (v % 2 == 1)) begin
        o.r = o.r / 2;
        o.g = o.g / 2;
        o.b = o.b / 2;
      end
`else
      if (sl) o.r = o.r;
`endif
    end
    return o;
  endfunction

  // Issue one cycle of stimulus and queue the response it should produce
  task automatic step(input logic rst, input logic [7:0] rgb, input logic sl);
    RESET = rst;
    RGB8  = rgb;
    SLEN  = sl;
    if (rst) begin
      exp_q0.push_back(reset_obs());
      exp_q1.push_back(reset_obs());
      n = 0;
    end else begin
      exp_q0.push_back(model(0, n, rgb, sl));
      exp_q1.push_back(model(1, n, rgb, sl));
      n = n + 1;
    end
    @(negedge VCLK);
  endtask

  function automatic logic [7:0] pick_rgb(int c);
    if (c >= 300 && c < 1300) return 8'hFF;
    if (c >= 1300 && c < 2300) return 8'h47;
    return 8'($urandom);
  endfunction

  task automatic compare(input int k, input obs_t act, input obs_t e);
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL out%0d t=%0t: got ph=%0d pv=%0d rgb=%02h%02h%02h hb=%b vb=%b hs=%b vs=%b fr=%b, want ph=%0d pv=%0d rgb=%02h%02h%02h hb=%b vb=%b hs=%b vs=%b fr=%b",
               k, $time, act.ph, act.pv, act.r, act.g, act.b, act.hb, act.vb, act.hs, act.vs,
               act.fr, e.ph, e.pv, e.r, e.g, e.b, e.hb, e.vb, e.hs, e.vs, e.fr);
    end
  endtask

  int cyc        = 0;
  int last_fr1   = -1;
  int frames1    = 0;

  // Monitor: pop and compare every cycle, just after the active edge
  always @(posedge VCLK) begin
    obs_t a, e;
    #1;
    cyc++;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = '{ph0, pv0, r0, g0, b0, hb0, vb0, hs0, vs0, fr0};
      compare(0, a, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = '{ph1, pv1, r1, g1, b1, hb1, vb1, hs1, vs1, fr1};
      compare(1, a, e);
    end
    // FRAME spacing on the small raster, restarted by any reset
    if (RESET) begin
      last_fr1 = -1;
    end else if (fr1) begin
      if (last_fr1 >= 0) begin
        n_cmp++;
        if (cyc - last_fr1 != S_HT * S_VT) begin
          n_bad++;
          $display("FAIL frame_period: got %0d cycles, want %0d", cyc - last_fr1, S_HT * S_VT);
        end
      end
      last_fr1 = cyc;
      frames1++;
    end
  end

  initial begin
    bit mid_done;
    mid_done = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 22000; c++) begin
      if (!mid_done && n == 50 * 384 + 100) begin
        step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
        mid_done = 1'b1;
      end else begin
        step(1'b0, pick_rgb(c), 1'($urandom_range(0, 1)));
      end
    end
    @(posedge VCLK);
    #2;
    n_cmp++;
    if (frames1 < 50) begin
      n_bad++;
      $display("FAIL frame_count: got %0d small-raster FRAME pulses, want at least 50", frames1);
    end
    n_cmp++;
    if (exp_q0.size() + exp_q1.size() > 1) begin
      n_bad++;
      $display("FAIL drain: got %0d queued, want at most 1", exp_q0.size() + exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
